// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: spreads |cmd_steps| Gray-coded A/B steps evenly over a fixed
// window using a Bresenham accumulator, and keeps a signed running position count.
module quad_enc_gen #(
  parameter int unsigned WINDOW_CYCLES = 500000,
  parameter int unsigned MIN_GAP       = 4,
  parameter int unsigned STEP_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [STEP_W-1:0] cmd_steps,
  output logic                     A,
  output logic                     B,
  output logic signed [31:0]       pos_count,
  output logic                     win_done,
  output logic                     sat
);

  localparam int unsigned NMax = WINDOW_CYCLES / MIN_GAP;
  localparam int unsigned AccW = $clog2(2 * WINDOW_CYCLES);
  localparam int unsigned CntW = $clog2(WINDOW_CYCLES + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] n_q;
  logic [CntW-1:0] win_cnt_q;
  logic            dir_q;

  logic [STEP_W:0] mag;
  logic            clamp;
  logic [AccW-1:0] n_load;
  logic [AccW-1:0] acc_sum;
  logic            last;
  logic            accept;
  logic            emit;

  // Magnitude is formed one bit wider so the most negative command does not overflow.
  always_comb begin
    mag = {1'b0, cmd_steps};
    if (cmd_steps[STEP_W-1]) begin
      mag = -{cmd_steps[STEP_W-1], cmd_steps};
    end
    clamp  = 32'(mag) > NMax;
    n_load = clamp ? AccW'(NMax) : AccW'(mag);
  end

  always_comb begin
    last      = (state_q == StRun) && (win_cnt_q == CntW'(WINDOW_CYCLES));
    cmd_ready = (state_q == StIdle) || last;
    win_done  = last;
    accept    = cmd_valid && cmd_ready;
    acc_sum   = acc_q + n_q;
    emit      = (state_q == StRun) && (acc_sum >= AccW'(WINDOW_CYCLES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      n_q       <= '0;
      win_cnt_q <= '0;
      dir_q     <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
      pos_count <= '0;
      sat       <= 1'b0;
    end else begin
      if (state_q == StRun) begin
        acc_q     <= emit ? acc_sum - AccW'(WINDOW_CYCLES) : acc_sum;
        win_cnt_q <= win_cnt_q + CntW'(1);
        if (emit) begin
          // Forward walks 00->10->11->01, reverse walks the same ring backwards.
          if (!dir_q) begin
            A         <= ~B;
            B         <= A;
            pos_count <= pos_count + 32'sd1;
          end else begin
            A         <= B;
            B         <= ~A;
            pos_count <= pos_count - 32'sd1;
          end
        end
        if (last && !accept) begin
          state_q <= StIdle;
        end
      end
      if (accept) begin
        state_q   <= StRun;
        win_cnt_q <= CntW'(1);
        acc_q     <= '0;
        n_q       <= n_load;
        dir_q     <= cmd_steps[STEP_W-1];
        if (clamp) begin
          sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen with a 100-cycle window, plus a loopback into a
// synchronising quadrature decoder.
module tb_quad_enc_gen;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [15:0] cmd_steps;
  logic               A;
  logic               B;
  logic signed [31:0] pos_count;
  logic               win_done;
  logic               sat;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] ab;
  assign ab = {A, B};

  logic [1:0] fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_enc_gen #(
    .WINDOW_CYCLES(100),
    .MIN_GAP      (4),
    .STEP_W       (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .A        (A),
    .B        (B),
    .pos_count(pos_count),
    .win_done (win_done),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: two-stage synchroniser, then x4 transition decode.
  logic [1:0] s1, s2, s3;
  int         dec_count;

  function automatic int dec_delta(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return -1;
      default:                            return 0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= 2'b00;
      s2        <= 2'b00;
      s3        <= 2'b00;
      dec_count <= 0;
    end else begin
      s1        <= {A, B};
      s2        <= s1;
      s3        <= s2;
      dec_count <= dec_count + dec_delta(s3, s2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_steps = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present a command for exactly one edge; caller guarantees cmd_ready is high.
  task automatic send(input logic signed [15:0] v);
    cmd_steps = v;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0;
    cmd_steps = '0;
    reset     = 1'b1;
    #2;
    n_vec++;
    if ({ab, pos_count, win_done, sat, cmd_ready} !== {2'b00, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: ab=%b pos=%0d done=%b sat=%b rdy=%b, want 00 0 0 0 1",
               ab, pos_count, win_done, sat, cmd_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (cmd_ready !== 1'b1 || ab !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: rdy=%b ab=%b, want 1 00", cmd_ready, ab);
    end
  endtask

  task automatic test_fwd();
    logic [1:0] exp_ab;
    do_reset();
    send(16'sd4);
    cmd_steps = -16'sd7;  // must not affect the running window
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp_ab = (k < 25) ? 2'b00 : (k < 50) ? 2'b10 : (k < 75) ? 2'b11 : (k < 100) ? 2'b01 : 2'b00;
      n_vec++;
      if (ab !== exp_ab) begin
        n_err++;
        $display("FAIL fwd_ab k=%0d: got %b want %b", k, ab, exp_ab);
      end
      n_vec++;
      if (win_done !== (k == 99) || cmd_ready !== (k >= 99)) begin
        n_err++;
        $display("FAIL fwd_done k=%0d: done=%b rdy=%b, want %b %b", k, win_done, cmd_ready,
                 k == 99, k >= 99);
      end
    end
    n_vec++;
    if (pos_count !== 32'sd4 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_end: pos=%0d sat=%b, want 4 0", pos_count, sat);
    end
  endtask

  task automatic test_rev();
    logic [1:0] exp_ab;
    do_reset();
    send(-16'sd3);
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp_ab = (k < 34) ? 2'b00 : (k < 67) ? 2'b01 : (k < 100) ? 2'b11 : 2'b10;
      n_vec++;
      if (ab !== exp_ab) begin
        n_err++;
        $display("FAIL rev_ab k=%0d: got %b want %b", k, ab, exp_ab);
      end
    end
    n_vec++;
    if (pos_count !== -32'sd3) begin
      n_err++;
      $display("FAIL rev_pos: got %0d want -3", pos_count);
    end
  endtask

  task automatic test_sat();
    do_reset();
    send(16'sd40);
    n_vec++;
    if (sat !== 1'b1) begin
      n_err++;
      $display("FAIL sat_set: got %b want 1", sat);
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_vec++;
      if (ab !== fwd_seq[(k / 4) % 4]) begin
        n_err++;
        $display("FAIL sat_ab k=%0d: got %b want %b", k, ab, fwd_seq[(k / 4) % 4]);
      end
    end
    n_vec++;
    if (pos_count !== 32'sd25) begin
      n_err++;
      $display("FAIL sat_pos: got %0d want 25", pos_count);
    end
    send(16'sd1);
    repeat (100) tick();
    n_vec++;
    if (sat !== 1'b1 || pos_count !== 32'sd26 || ab !== 2'b11) begin
      n_err++;
      $display("FAIL sat_sticky: sat=%b pos=%0d ab=%b, want 1 26 11", sat, pos_count, ab);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_steps = 16'sd2;
    cmd_valid = 1'b1;
    tick();
    cmd_steps = -16'sd2;
    for (int k = 1; k <= 300; k++) begin
      n_vec++;
      if (cmd_ready !== (k == 100 || k == 200 || k == 300)) begin
        n_err++;
        $display("FAIL b2b_ready edge %0d: got %b want %b", k, cmd_ready,
                 k == 100 || k == 200 || k == 300);
      end
      tick();
      if (k == 100) begin
        n_vec++;
        if (pos_count !== 32'sd2 || ab !== 2'b11) begin
          n_err++;
          $display("FAIL b2b_w1: pos=%0d ab=%b, want 2 11", pos_count, ab);
        end
        cmd_steps = 16'sd0;
      end else if (k == 200) begin
        n_vec++;
        if (pos_count !== 32'sd0 || ab !== 2'b00) begin
          n_err++;
          $display("FAIL b2b_w2: pos=%0d ab=%b, want 0 00", pos_count, ab);
        end
        cmd_valid = 1'b0;
      end else if (k > 200) begin
        n_vec++;
        if (ab !== 2'b00 || pos_count !== 32'sd0) begin
          n_err++;
          $display("FAIL b2b_zero k=%0d: ab=%b pos=%0d, want 00 0", k, ab, pos_count);
        end
      end
    end
    n_vec++;
    if (cmd_ready !== 1'b1 || win_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: rdy=%b done=%b, want 1 0", cmd_ready, win_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(16'sd4);
    repeat (60) tick();
    n_vec++;
    if (ab !== 2'b11 || pos_count !== 32'sd2) begin
      n_err++;
      $display("FAIL mid_pre: ab=%b pos=%0d, want 11 2", ab, pos_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (ab !== 2'b00 || pos_count !== 32'sd0) begin
      n_err++;
      $display("FAIL mid_async: ab=%b pos=%0d, want 00 0", ab, pos_count);
    end
    tick();
    reset = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_idle: rdy=%b want 1", cmd_ready);
    end
    send(16'sd1);
    repeat (99) tick();
    n_vec++;
    if (ab !== 2'b00) begin
      n_err++;
      $display("FAIL mid_hold: ab=%b want 00", ab);
    end
    tick();
    n_vec++;
    if (ab !== 2'b10 || pos_count !== 32'sd1) begin
      n_err++;
      $display("FAIL mid_restart: ab=%b pos=%0d, want 10 1", ab, pos_count);
    end
  endtask

  task automatic test_loopback();
    int model = 0;
    int v;
    do_reset();
    for (int w = 0; w < 50; w++) begin
      v         = int'($urandom_range(50, 0)) - 25;
      cmd_steps = 16'(v);
      cmd_valid = 1'b1;
      wait_ready();
      tick();
      if (w > 0) begin
        repeat (3) tick();
        n_vec++;
        if (dec_count !== model || pos_count !== model) begin
          n_err++;
          $display("FAIL loop_w%0d: dec=%0d pos=%0d, want %0d", w, dec_count, pos_count, model);
        end
      end
      model += v;
    end
    cmd_valid = 1'b0;
    wait_ready();
    tick();
    repeat (3) tick();
    n_vec++;
    if (dec_count !== model || pos_count !== model) begin
      n_err++;
      $display("FAIL loop_end: dec=%0d pos=%0d, want %0d", dec_count, pos_count, model);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    #1;
    test_reset();
    test_fwd();
    test_rev();
    test_sat();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
